// File: rtl/eth_stream_pkg.sv
// Shared definitions for the Ethernet stream frame FIFO.
// Provides keep-width / storage-entry typedefs for the default 32-bit stream,
// width helper functions for parameterised instances, and the read-FSM
// state encoding. No ports (package).
package eth_stream_pkg;

    localparam int ETH_DATA_WIDTH = 32;
    localparam int ETH_KEEP_WIDTH = $clog2(ETH_DATA_WIDTH / 8);

    typedef logic [ETH_KEEP_WIDTH-1:0] keep_t;

    // One stored beat: data, byte count (meaningful on last beats), end-of-frame flag.
    typedef struct packed {
        logic [ETH_DATA_WIDTH-1:0] data;
        keep_t                     keep;
        logic                      last;
    } entry_t;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_FETCH = 2'd1,
        RD_SEND  = 2'd2
    } rd_state_t;

    // Width of the keep field for a given stream data width.
    function automatic int keep_width(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    // Width of one storage entry {data, keep, last} for a given data width.
    function automatic int entry_width(input int data_width);
        return data_width + keep_width(data_width) + 1;
    endfunction

endpackage

// File: rtl/eth_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// (1-cycle) read. Contents are not reset.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_en/rd_addr read request;
// rd_data read result, valid the cycle after rd_en.
module eth_sdp_ram #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holds its value when no read is requested.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/eth_stream_frame_fifo.sv
// Store-and-forward frame FIFO for an Ethernet beat stream.
// A frame is only forwarded once its last beat has been accepted without
// abort; aborted frames and frames that do not fit are discarded.
// Ports: i_clk/i_rst (sync active-high); i_eth_slave_* upstream stream;
// o_eth_master_* filtered downstream stream (abort tied 0); o_drop_pulse
// one pulse per aborted frame; o_overflow_pulse one pulse per frame lost to
// full storage.
module eth_stream_frame_fifo
    import eth_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 512
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [DATA_WIDTH-1:0]           i_eth_slave_data,
    input  logic [$clog2(DATA_WIDTH/8)-1:0] i_eth_slave_keep,
    input  logic                            i_eth_slave_valid,
    input  logic                            i_eth_slave_abort,
    input  logic                            i_eth_slave_last,
    output logic [DATA_WIDTH-1:0]           o_eth_master_data,
    output logic [$clog2(DATA_WIDTH/8)-1:0] o_eth_master_keep,
    output logic                            o_eth_master_valid,
    output logic                            o_eth_master_abort,
    output logic                            o_eth_master_last,
    output logic                            o_drop_pulse,
    output logic                            o_overflow_pulse
);

    localparam int KEEP_W  = keep_width(DATA_WIDTH);
    localparam int ENTRY_W = entry_width(DATA_WIDTH);
    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int PTR_W   = ADDR_W + 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      commit_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [PTR_W-1:0]      occupancy_s;
    logic                  full_s;
    logic                  wr_en_s;
    logic                  commit_s;
    logic                  dropping_r;
    logic                  drop_pulse_r;
    logic                  ovf_pulse_r;
    logic [CNT_W-1:0]      frame_cnt_r;
    rd_state_t             state_r;
    rd_state_t             state_nxt_s;
    logic                  rd_en_s;
    logic [ENTRY_W-1:0]    rd_entry_s;
    logic                  rd_last_s;
    logic [KEEP_W-1:0]     rd_keep_s;
    logic [DATA_WIDTH-1:0] rd_data_s;
    logic                  send_last_s;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic [KEEP_W-1:0]     out_keep_r;
    logic                  out_valid_r;
    logic                  out_last_r;

    // Occupancy uses the read pointer as it stands this cycle, so a slot
    // being read in the same cycle is not yet counted as free.
    assign occupancy_s = wr_ptr_r - rd_ptr_r;
    assign full_s      = (occupancy_s == DEPTH_P);

    assign rd_last_s   = rd_entry_s[0];
    assign rd_keep_s   = rd_entry_s[KEEP_W:1];
    assign rd_data_s   = rd_entry_s[ENTRY_W-1:KEEP_W+1];
    assign send_last_s = (state_r == RD_SEND) && rd_last_s;

    // Store a beat only when it is neither aborted, discarded, nor blocked by full storage.
    always_comb begin
        wr_en_s  = 1'b0;
        commit_s = 1'b0;
        if (i_eth_slave_valid && !dropping_r && !i_eth_slave_abort && !full_s) begin
            wr_en_s  = 1'b1;
            commit_s = i_eth_slave_last;
        end else begin
            wr_en_s  = 1'b0;
            commit_s = 1'b0;
        end
    end

    // Write side: pointer advance, commit, abort rewind and overflow discard.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_r     <= {PTR_W{1'b0}};
            commit_ptr_r <= {PTR_W{1'b0}};
            dropping_r   <= 1'b0;
            drop_pulse_r <= 1'b0;
            ovf_pulse_r  <= 1'b0;
        end else begin
            drop_pulse_r <= 1'b0;
            ovf_pulse_r  <= 1'b0;
            if (i_eth_slave_valid) begin
                if (dropping_r) begin
                    // Discarding the rest of an overflowed frame; pulse at its end.
                    if (i_eth_slave_last || i_eth_slave_abort) begin
                        dropping_r  <= 1'b0;
                        ovf_pulse_r <= 1'b1;
                    end
                end else if (i_eth_slave_abort) begin
                    wr_ptr_r     <= commit_ptr_r;
                    drop_pulse_r <= 1'b1;
                end else if (full_s) begin
                    // A full hit on the terminating beat ends the frame at once.
                    wr_ptr_r <= commit_ptr_r;
                    if (i_eth_slave_last) begin
                        ovf_pulse_r <= 1'b1;
                    end else begin
                        dropping_r <= 1'b1;
                    end
                end else begin
                    wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                    if (i_eth_slave_last) begin
                        commit_ptr_r <= wr_ptr_r + PTR_W'(1);
                    end
                end
            end
        end
    end

    eth_sdp_ram #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (i_clk),
        .wr_en   (wr_en_s),
        .wr_addr (wr_ptr_r[ADDR_W-1:0]),
        .wr_data ({i_eth_slave_data, i_eth_slave_keep, i_eth_slave_last}),
        .rd_en   (rd_en_s),
        .rd_addr (rd_ptr_r[ADDR_W-1:0]),
        .rd_data (rd_entry_s)
    );

    // Read FSM next state; in SEND the RAM output always holds a fresh beat.
    always_comb begin
        state_nxt_s = state_r;
        rd_en_s     = 1'b0;
        case (state_r)
            RD_IDLE: begin
                if (frame_cnt_r != {CNT_W{1'b0}}) begin
                    state_nxt_s = RD_FETCH;
                end else begin
                    state_nxt_s = RD_IDLE;
                end
            end
            RD_FETCH: begin
                rd_en_s     = 1'b1;
                state_nxt_s = RD_SEND;
            end
            RD_SEND: begin
                if (rd_last_s) begin
                    state_nxt_s = RD_IDLE;
                end else begin
                    rd_en_s     = 1'b1;
                    state_nxt_s = RD_SEND;
                end
            end
            default: begin
                state_nxt_s = RD_IDLE;
            end
        endcase
    end

    // Read FSM state, read pointer and committed-frame counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= RD_IDLE;
            rd_ptr_r    <= {PTR_W{1'b0}};
            frame_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({commit_s, send_last_s})
                2'b10:   frame_cnt_r <= frame_cnt_r + CNT_W'(1);
                2'b01:   frame_cnt_r <= frame_cnt_r - CNT_W'(1);
                default: frame_cnt_r <= frame_cnt_r;
            endcase
        end
    end

    // Registered output stage; everything is zero outside SEND.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_keep_r  <= {KEEP_W{1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else if (state_r == RD_SEND) begin
            out_data_r  <= rd_data_s;
            out_keep_r  <= rd_last_s ? rd_keep_s : {KEEP_W{1'b0}};
            out_valid_r <= 1'b1;
            out_last_r  <= rd_last_s;
        end else begin
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_keep_r  <= {KEEP_W{1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end
    end

    assign o_eth_master_data  = out_data_r;
    assign o_eth_master_keep  = out_keep_r;
    assign o_eth_master_valid = out_valid_r;
    assign o_eth_master_last  = out_last_r;
    assign o_eth_master_abort = 1'b0;
    assign o_drop_pulse       = drop_pulse_r;
    assign o_overflow_pulse   = ovf_pulse_r;

endmodule

// File: tb/tb_eth_stream_frame_fifo.sv
// Self-checking bench for eth_stream_frame_fifo (DATA_WIDTH=32, DEPTH=16).
// Directed frames are driven by the main process, which pushes the beats it
// expects to see into a queue; a negedge monitor pops and compares every
// output beat and counts drop/overflow pulses.
module tb_eth_stream_frame_fifo;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  k;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_data;
    logic [1:0]  s_keep;
    logic        s_valid;
    logic        s_abort;
    logic        s_last;
    logic [31:0] m_data;
    logic [1:0]  m_keep;
    logic        m_valid;
    logic        m_abort;
    logic        m_last;
    logic        drop_pulse;
    logic        ovf_pulse;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    last_edge = 0;
    int    drop_cnt = 0;
    int    ovf_cnt  = 0;
    int    out_beats = 0;
    bit    mon_en   = 1'b0;
    bit    rst_flush = 1'b0;
    bit    in_frame = 1'b0;
    beat_t exp_q[$];
    int    first_q[$];
    int    last_q[$];

    eth_stream_frame_fifo #(
        .DATA_WIDTH (32),
        .DEPTH      (16)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_eth_slave_data   (s_data),
        .i_eth_slave_keep   (s_keep),
        .i_eth_slave_valid  (s_valid),
        .i_eth_slave_abort  (s_abort),
        .i_eth_slave_last   (s_last),
        .o_eth_master_data  (m_data),
        .o_eth_master_keep  (m_keep),
        .o_eth_master_valid (m_valid),
        .o_eth_master_abort (m_abort),
        .o_eth_master_last  (m_last),
        .o_drop_pulse       (drop_pulse),
        .o_overflow_pulse   (ovf_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Scoreboard monitor: compares each output beat with the head of exp_q.
    always @(negedge clk) begin
        beat_t e;
        if (mon_en) begin
            if (rst_flush) begin
                in_frame  = 1'b0;
                rst_flush = 1'b0;
            end
            if (drop_pulse === 1'b1) drop_cnt++;
            if (ovf_pulse === 1'b1) ovf_cnt++;
            if (m_valid === 1'b1) begin
                if (!in_frame) first_q.push_back(cyc);
                in_frame = 1'b1;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got data %0h, expected no beat", m_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", 64'(m_data), 64'(e.d));
                    chk("out_keep", 64'(m_keep), 64'(e.k));
                    chk("out_last", 64'(m_last), 64'(e.l));
                    chk("out_abort", 64'(m_abort), 64'd0);
                end
                if (m_last === 1'b1) begin
                    in_frame = 1'b0;
                    last_q.push_back(cyc);
                end
                out_beats++;
            end else begin
                if (in_frame) begin
                    chk("frame_gap", 64'(m_valid), 64'd1);
                    in_frame = 1'b0;
                end
                chk("idle_zero", 64'({m_data, m_keep, m_last, m_abort}), 64'd0);
            end
        end
    end

    task automatic idle_in();
        s_valid = 1'b0;
        s_data  = 32'd0;
        s_keep  = 2'd0;
        s_abort = 1'b0;
        s_last  = 1'b0;
    endtask

    // Drive one frame; non-last beats carry keep=3 to show it is masked on output.
    task automatic send_frame(input int id, input int nbeats, input logic [1:0] last_keep,
                              input int abort_at, input bit good);
        beat_t b;
        for (int i = 0; i < nbeats; i++) begin
            s_valid = 1'b1;
            s_data  = {8'hF0, 8'(id), 8'h5A, 8'(i)};
            s_last  = (i == nbeats - 1);
            s_abort = (i == abort_at);
            s_keep  = s_last ? last_keep : 2'd3;
            if (good) begin
                b.d = s_data;
                b.k = s_last ? last_keep : 2'd0;
                b.l = s_last;
                exp_q.push_back(b);
            end
            @(posedge clk);
            #1;
            if (s_last || s_abort) last_edge = cyc;
            if (s_abort) break;
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !in_frame) break;
        end
        repeat (8) @(negedge clk);
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int d0;
        int o0;
        int b0;
        rst = 1'b1;
        idle_in();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("reset_outputs", 64'({m_data, m_keep, m_valid, m_last, m_abort, drop_pulse, ovf_pulse}), 64'd0);

        // 4-beat frame, keep=2 on last; first output 3 edges after input last.
        first_q.delete();
        last_q.delete();
        send_frame(1, 4, 2'd2, -1, 1'b1);
        idle_in();
        drain("t1_drain");
        chk("t1_frames_out", 64'(first_q.size()), 64'd1);
        if (first_q.size() > 0) chk("t1_latency", 64'(first_q[0] - last_edge), 64'd3);

        // Aborted 3-beat frame followed by a good 2-beat frame.
        d0 = drop_cnt;
        o0 = ovf_cnt;
        send_frame(2, 3, 2'd1, 1, 1'b0);
        send_frame(3, 2, 2'd0, -1, 1'b1);
        idle_in();
        drain("t2_drain");
        chk("t2_drop_pulses", 64'(drop_cnt - d0), 64'd1);
        chk("t2_ovf_pulses", 64'(ovf_cnt - o0), 64'd0);

        // Abort together with last on beat 4.
        d0 = drop_cnt;
        send_frame(4, 4, 2'd3, 3, 1'b0);
        idle_in();
        repeat (30) @(negedge clk);
        chk("t3_drop_pulses", 64'(drop_cnt - d0), 64'd1);

        // 20-beat frame overflows 16-entry storage; next 4-beat frame passes.
        d0 = drop_cnt;
        o0 = ovf_cnt;
        send_frame(5, 20, 2'd1, -1, 1'b0);
        idle_in();
        repeat (30) @(negedge clk);
        chk("t4_ovf_pulses", 64'(ovf_cnt - o0), 64'd1);
        chk("t4_drop_pulses", 64'(drop_cnt - d0), 64'd0);
        send_frame(6, 4, 2'd1, -1, 1'b1);
        idle_in();
        drain("t4_drain");

        // Three 5-beat frames back-to-back: exactly 2 idle cycles between outputs.
        first_q.delete();
        last_q.delete();
        send_frame(7, 5, 2'd3, -1, 1'b1);
        send_frame(8, 5, 2'd0, -1, 1'b1);
        send_frame(9, 5, 2'd2, -1, 1'b1);
        idle_in();
        drain("t5_drain");
        chk("t5_frames_out", 64'(first_q.size()), 64'd3);
        if (first_q.size() == 3 && last_q.size() == 3) begin
            for (int i = 0; i < 2; i++) begin
                chk("t5_gap", 64'(first_q[i+1] - last_q[i] - 1), 64'd2);
            end
        end

        // Reset during output beat 2 of a 6-beat frame.
        b0 = out_beats;
        send_frame(10, 6, 2'd1, -1, 1'b1);
        idle_in();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (out_beats - b0 >= 2) break;
        end
        chk("t6_beats_before_rst", 64'(out_beats - b0), 64'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rst_flush = 1'b1;
        exp_q.delete();
        @(negedge clk);
        #1;
        chk("t6_valid_after_rst", 64'(m_valid), 64'd0);
        chk("t6_frame_cnt", 64'(dut.frame_cnt_r), 64'd0);
        repeat (20) @(negedge clk);
        send_frame(11, 3, 2'd3, -1, 1'b1);
        idle_in();
        drain("t6_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/eth_stream_frame_fifo.md
ETH_STREAM_FRAME_FIFO -- requirements
Module: eth_stream_frame_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, stream data width in bits; multiple of 8, at least 16.
REQ-002 SHALL have parameter DEPTH, default 512, storage depth in beats; power of two.
REQ-003 SHALL have port i_clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port i_rst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports i_eth_slave_data/keep/valid/abort/last  input  DATA_WIDTH/$clog2(DATA_WIDTH/8)/1/1/1  upstream frame stream.
REQ-006 SHALL have ports o_eth_master_data/keep/valid/abort/last  output  same widths  filtered downstream frame stream.
REQ-007 SHALL have port o_drop_pulse  output  1  one-cycle pulse per frame discarded due to abort.
REQ-008 SHALL have port o_overflow_pulse  output  1  one-cycle pulse per frame discarded due to full storage.

Function
REQ-009 SHALL be a store-and-forward frame FIFO; a frame reaches the output only after its last beat has been accepted without abort.
REQ-010 SHALL sample keep/abort/last only while valid is high; keep is the valid-byte count modulo DATA_WIDTH/8, with 0 meaning all bytes; it is meaningful on last beats only and SHALL be stored and replayed unchanged.
REQ-011 SHALL write each valid beat {data, keep, last} at the write pointer and advance it; the committed pointer SHALL update to the write pointer +1 on a last beat without abort.
REQ-012 SHALL treat a valid beat with abort high, including one with last also high, as the end of the frame: not stored, write pointer restored to committed pointer, o_drop_pulse high next cycle.
REQ-013 SHALL, when a valid beat arrives with occupancy (write minus read pointer) equal to DEPTH, enter DROP: restore write pointer to committed, discard beats through the next last or abort, and pulse o_overflow_pulse once at that terminating beat.
REQ-014 SHALL count committed-but-unsent frames in a counter of width $clog2(DEPTH+1); increment on commit, decrement on output last; both in one cycle leaves it unchanged.
REQ-015 SHALL implement the read FSM as IDLE -> FETCH when frame count > 0 -> SEND -> IDLE after the output last beat; FETCH issues the first RAM read.
REQ-016 SHALL, in SEND, present one beat per cycle with no gaps until last, since the whole frame is already stored and there is no backpressure.
REQ-017 SHALL give latency from input last beat (edge T) to first output beat valid at edge T+3 when IDLE; consecutive output frames SHALL be separated by exactly 2 idle cycles (IDLE, FETCH).
REQ-018 SHALL drive o_eth_master_abort constant 0, o_eth_master_keep 0 on non-last beats, and data/keep/last 0 when valid is low.
REQ-019 SHALL handle same-cycle input commit and output read of the last free slot correctly; occupancy uses the read pointer as of that cycle.
REQ-020 SHALL use pointers of $clog2(DEPTH)+1 bits, wrapping naturally; full is occupancy equal to DEPTH, empty is equal pointers.

Reset
REQ-021 SHALL, on i_rst high at a clock edge, clear all pointers, frame count and pulses, put FSM to IDLE and write side out of DROP; all outputs 0 on the following cycle.
REQ-022 SHALL discard any partially received or partially sent frame on reset mid-operation; RAM contents need no reset.

Structure
REQ-023 SHALL take keep-width and storage-entry typedefs from the shared package eth_stream_pkg.
REQ-024 SHALL instantiate one sub-module eth_sdp_ram: simple dual-port RAM, one write port, one read port with 1-cycle registered read.

Verification (DATA_WIDTH=32, DEPTH=16)
REQ-025 SHALL cover: 4-beat frame, last beat keep=2, no abort -> identical 4 beats out, first valid 3 cycles after input last, keep=2 on last beat only.
REQ-026 SHALL cover: 3-beat frame with abort on beat 2 then 2-beat good frame -> only the 2-beat frame output; o_drop_pulse exactly once.
REQ-027 SHALL cover: abort and last together on beat 4 -> no output, one o_drop_pulse.
REQ-028 SHALL cover: 20-beat frame -> no output, one o_overflow_pulse at its last beat; following 4-beat frame passes intact.
REQ-029 SHALL cover: three 5-beat frames back-to-back -> three frames out in order, each separated by exactly 2 idle cycles.
REQ-030 SHALL cover: i_rst pulsed during output beat 2 of a 6-beat frame -> valid 0 next cycle, frame count 0, next input frame passes normally.
